// File: rtl/layer2_weight_buffer.sv
// rtl/layer2_weight_buffer.sv - layer-2 weight set sink: stream load into RAM, random-access read-out
module layer2_weight_buffer #(
    parameter int DEPTH = 576,
    parameter int AW    = 10,
    parameter int DW    = 64
) (
    input  logic          sclk,
    input  logic          s_rst,
    input  logic [DW-1:0] weight_data,
    input  logic          weight_valid,
    input  logic          weight_last,
    output logic          ready,
    input  logic          load_start,
    output logic          load_done,
    output logic          load_err,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] END_ADDR  = AW'(DEPTH);

    state_t        state, state_nxt;
    logic [AW-1:0] wr_addr;
    logic          accept, at_end, load_end, rd_go;
    logic [DW-1:0] mem [DEPTH];

    assign accept   = weight_valid & ready;
    assign at_end   = (wr_addr == LAST_ADDR);
    // a set ends on the tagged last beat or when the RAM is full, whichever comes first
    assign load_end = accept & (weight_last | at_end);
    assign rd_go    = rd_en & load_done;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load_start) state_nxt = LOAD;
            LOAD:    if (load_end)   state_nxt = DONE;
            DONE:    if (load_start) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            state     <= IDLE;
            ready     <= 1'b0;
            wr_addr   <= '0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            ready <= (state_nxt == LOAD);
            if (state != LOAD && load_start) begin
                wr_addr   <= '0;
                load_done <= 1'b0;
                load_err  <= 1'b0;
            end else if (accept) begin
                wr_addr <= wr_addr + 1'b1;
                if (load_end) begin
                    load_done <= 1'b1;
                    load_err  <= ~(weight_last & at_end);
                end
            end
        end
    end

    // RAM is deliberately left out of reset
    always_ff @(posedge sclk) begin
        if (accept) mem[wr_addr] <= weight_data;
    end

    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_go;
            if (rd_go) rd_data <= (rd_addr < END_ADDR) ? mem[rd_addr] : '0;
        end
    end

endmodule
